// File: rtl/cascade_sequencer_pkg.sv
// cascade_sequencer_pkg: shared ack-state encoding, ICW4 bit positions and lowest-set-bit helper
package cascade_sequencer_pkg;
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ACK1 = 2'd1;
  localparam logic [1:0] STATE_ACK2 = 2'd2;
  localparam logic [1:0] STATE_ACK3 = 2'd3;
  localparam int ICW4_UPM = 0;
  localparam int ICW4_MS = 2;
  localparam int ICW4_BUF = 3;
  typedef enum logic [1:0] {
    ACK_IDLE = STATE_IDLE,
    ACK_1 = STATE_ACK1,
    ACK_2 = STATE_ACK2,
    ACK_3 = STATE_ACK3
  } ack_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ACK1, S_GAP1, S_ACK2, S_GAP2, S_ACK3} seq_state_t;
  function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
    lowest_set_index = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) lowest_set_index = 5'(i);
  endfunction
endpackage

// File: rtl/cascade_sequencer_if.sv
// cascade_sequencer_if: control-side and CAS-side signals of the cascade sequencer (buffer_enable_n with BUFFERED_MODE_EN)
interface cascade_sequencer_if #(parameter int IR_COUNT = 8);
  import cascade_sequencer_pkg::*;
  localparam int ID_WIDTH = $clog2(IR_COUNT);
  logic icw1_write;
  logic icw3_write;
  logic icw4_write;
  logic [IR_COUNT-1:0] icw_data;
  logic single_mode;
  logic slave_program_n;
  logic interrupt_ack_n;
  logic [IR_COUNT-1:0] acknowledge_interrupt;
  logic [ID_WIDTH-1:0] cascade_in;
  logic [ID_WIDTH-1:0] cascade_out;
  logic cascade_oe;
  logic cascade_slave;
  logic vector_drive_enable;
  ack_state_t ack_state;
  logic sequence_done;
`ifdef BUFFERED_MODE_EN
  logic buffer_enable_n;
`endif
  modport master (
`ifdef BUFFERED_MODE_EN
    input buffer_enable_n,
`endif
    output icw1_write, icw3_write, icw4_write, icw_data, single_mode, slave_program_n,
    output interrupt_ack_n, acknowledge_interrupt, cascade_in,
    input cascade_out, cascade_oe, cascade_slave, vector_drive_enable, ack_state, sequence_done
  );
  modport slave (
`ifdef BUFFERED_MODE_EN
    output buffer_enable_n,
`endif
    input icw1_write, icw3_write, icw4_write, icw_data, single_mode, slave_program_n,
    input interrupt_ack_n, acknowledge_interrupt, cascade_in,
    output cascade_out, cascade_oe, cascade_slave, vector_drive_enable, ack_state, sequence_done
  );
endinterface

// File: rtl/cascade_sequencer_inta_edge_detect.sv
// inta_edge_detect: registers INTA# and flags falling/rising edges against the registered level
module inta_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic level_n,
  output logic fall,
  output logic rise
);
  logic level_q, level_d;
  assign level_d = level_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) level_q <= 1'b1;
    else level_q <= level_d;
  assign fall = level_q & ~level_n;
  assign rise = ~level_q & level_n;
endmodule

// File: rtl/cascade_sequencer.sv
// cascade_sequencer: PIC cascade config, INTA pulse FSM, CAS drive/match and vector gating (BUFFERED_MODE_EN: ICW4 BUF/M-S select + buffer_enable_n)
module cascade_sequencer #(parameter int IR_COUNT = 8) (
  input logic clock,
  input logic reset_n,
  cascade_sequencer_if.slave bus
);
  import cascade_sequencer_pkg::*;
  localparam int ID_WIDTH = $clog2(IR_COUNT);
  logic fall, rise;
  seq_state_t state_q, state_d;
  logic [IR_COUNT-1:0] cfg_q, cfg_d, ack_ir_q, ack_ir_d;
  logic mode_8086_q, mode_8086_d, slave_hit_q, slave_hit_d, done_q, done_d;
  logic slave, master, from_slave, active, vec_en;
  ack_state_t ack;
  inta_edge_detect u_edge (.clock(clock), .reset_n(reset_n), .level_n(bus.interrupt_ack_n), .fall(fall), .rise(rise));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cfg_q <= '0;
      ack_ir_q <= '0;
      mode_8086_q <= 1'b0;
      slave_hit_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      ack_ir_q <= ack_ir_d;
      mode_8086_q <= mode_8086_d;
      slave_hit_q <= slave_hit_d;
      done_q <= done_d;
    end
  always_comb begin
    state_d = state_q;
    cfg_d = bus.icw3_write ? bus.icw_data : cfg_q;
    mode_8086_d = bus.icw4_write ? bus.icw_data[ICW4_UPM] : mode_8086_q;
    ack_ir_d = ack_ir_q;
    slave_hit_d = slave_hit_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_ACK1;
        ack_ir_d = bus.acknowledge_interrupt;
        slave_hit_d = bus.cascade_in == cfg_q[ID_WIDTH-1:0];
      end
      S_ACK1: state_d = rise ? S_GAP1 : S_ACK1;
      S_GAP1: state_d = fall ? S_ACK2 : S_GAP1;
      S_ACK2: if (rise) begin
        state_d = mode_8086_q ? S_IDLE : S_GAP2;
        done_d = mode_8086_q;
      end
      S_GAP2: state_d = fall ? S_ACK3 : S_GAP2;
      S_ACK3: if (rise) begin
        state_d = S_IDLE;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.icw1_write) begin
      state_d = S_IDLE;
      cfg_d = '0;
      mode_8086_d = 1'b0;
      ack_ir_d = '0;
      slave_hit_d = 1'b0;
      done_d = 1'b0;
    end
  end
`ifdef BUFFERED_MODE_EN
  logic buf_q, buf_d, ms_q, ms_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      buf_q <= 1'b0;
      ms_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      ms_q <= ms_d;
    end
  always_comb begin
    buf_d = bus.icw1_write ? 1'b0 : bus.icw4_write ? bus.icw_data[ICW4_BUF] : buf_q;
    ms_d = bus.icw1_write ? 1'b0 : bus.icw4_write ? bus.icw_data[ICW4_MS] : ms_q;
  end
  assign slave = ~bus.single_mode & (buf_q ? ~ms_q : ~bus.slave_program_n);
  assign bus.buffer_enable_n = ~vec_en;
`else
  assign slave = ~bus.single_mode & ~bus.slave_program_n;
`endif
  always_comb begin
    master = ~slave & ~bus.single_mode;
    from_slave = |(ack_ir_q & cfg_q);
    active = state_q != S_IDLE;
    ack = state_q == S_IDLE ? ACK_IDLE
        : (state_q == S_ACK1 || state_q == S_GAP1) ? ACK_1
        : (state_q == S_ACK2 || state_q == S_GAP2) ? ACK_2 : ACK_3;
    vec_en = (ack == ACK_2 || ack == ACK_3) & (bus.single_mode ? 1'b1 : slave ? slave_hit_q : ~from_slave);
  end
  assign bus.cascade_slave = slave;
  assign bus.cascade_oe = master & active & from_slave;
  assign bus.cascade_out = bus.cascade_oe ? ID_WIDTH'(lowest_set_index(32'(ack_ir_q))) : '0;
  assign bus.vector_drive_enable = vec_en;
  assign bus.ack_state = ack;
  assign bus.sequence_done = done_q;
endmodule

// File: tb/tb_cascade_sequencer.sv
// tb_cascade_sequencer: directed INTA sequences with immediate-assertion checks
module tb_cascade_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  cascade_sequencer_if #(.IR_COUNT(8)) bus ();
  cascade_sequencer #(.IR_COUNT(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic inta_low();
    bus.interrupt_ack_n = 1'b0;
    tick();
  endtask
  task automatic inta_high();
    bus.interrupt_ack_n = 1'b1;
    tick();
  endtask
  task automatic wr_icw3(input logic [7:0] d);
    bus.icw3_write = 1'b1;
    bus.icw_data = d;
    tick();
    bus.icw3_write = 1'b0;
  endtask
  task automatic wr_icw4(input logic [7:0] d);
    bus.icw4_write = 1'b1;
    bus.icw_data = d;
    tick();
    bus.icw4_write = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.icw1_write = 0; bus.icw3_write = 0; bus.icw4_write = 0; bus.icw_data = 0;
    bus.single_mode = 0; bus.slave_program_n = 1; bus.interrupt_ack_n = 1;
    bus.acknowledge_interrupt = 0; bus.cascade_in = 0;
    tick();
    tick();
    chk("rst_oe", 8'(bus.cascade_oe), 8'd0);
    chk("rst_out", 8'(bus.cascade_out), 8'd0);
    chk("rst_state", 8'(bus.ack_state), 8'd0);
    chk("rst_vec", 8'(bus.vector_drive_enable), 8'd0);
    chk("rst_done", 8'(bus.sequence_done), 8'd0);
    chk("rst_slave", 8'(bus.cascade_slave), 8'd0);
`ifdef BUFFERED_MODE_EN
    chk("rst_buf_en_n", 8'(bus.buffer_enable_n), 8'd1);
`endif
    reset_n = 1'b1;
    tick();
    wr_icw3(8'h04);
    wr_icw4(8'h01);
    bus.acknowledge_interrupt = 8'h04;
    inta_low();
    chk("m_from_slave_ack1_state", 8'(bus.ack_state), 8'd1);
    chk("m_from_slave_ack1_oe", 8'(bus.cascade_oe), 8'd1);
    chk("m_from_slave_ack1_out", 8'(bus.cascade_out), 8'd2);
    chk("m_from_slave_ack1_vec", 8'(bus.vector_drive_enable), 8'd0);
    inta_high();
    chk("m_from_slave_gap1_state", 8'(bus.ack_state), 8'd1);
    chk("m_from_slave_gap1_oe", 8'(bus.cascade_oe), 8'd1);
    chk("m_from_slave_gap1_done", 8'(bus.sequence_done), 8'd0);
    inta_low();
    chk("m_from_slave_ack2_state", 8'(bus.ack_state), 8'd2);
    chk("m_from_slave_ack2_out", 8'(bus.cascade_out), 8'd2);
    chk("m_from_slave_ack2_vec", 8'(bus.vector_drive_enable), 8'd0);
    inta_high();
    chk("m_from_slave_end_state", 8'(bus.ack_state), 8'd0);
    chk("m_from_slave_end_done", 8'(bus.sequence_done), 8'd1);
    chk("m_from_slave_end_oe", 8'(bus.cascade_oe), 8'd0);
    tick();
    chk("m_from_slave_done_once", 8'(bus.sequence_done), 8'd0);
    bus.acknowledge_interrupt = 8'h01;
    inta_low();
    chk("m_own_ack1_oe", 8'(bus.cascade_oe), 8'd0);
    chk("m_own_ack1_out", 8'(bus.cascade_out), 8'd0);
    inta_high();
    inta_low();
    chk("m_own_ack2_vec", 8'(bus.vector_drive_enable), 8'd1);
    chk("m_own_ack2_oe", 8'(bus.cascade_oe), 8'd0);
    inta_high();
    chk("m_own_done", 8'(bus.sequence_done), 8'd1);
    bus.acknowledge_interrupt = 8'h0C;
    inta_low();
    chk("m_multihot_oe", 8'(bus.cascade_oe), 8'd1);
    chk("m_multihot_out", 8'(bus.cascade_out), 8'd2);
    inta_high();
    inta_low();
    inta_high();
    bus.acknowledge_interrupt = 8'h00;
    inta_low();
    inta_high();
    inta_low();
    chk("m_spurious_oe", 8'(bus.cascade_oe), 8'd0);
    chk("m_spurious_vec", 8'(bus.vector_drive_enable), 8'd1);
    inta_high();
    bus.slave_program_n = 1'b0;
    wr_icw3(8'h03);
    wr_icw4(8'h00);
    chk("s_cascade_slave", 8'(bus.cascade_slave), 8'd1);
    bus.cascade_in = 3'd3;
    inta_low();
    chk("s_hit_ack1_vec", 8'(bus.vector_drive_enable), 8'd0);
    chk("s_hit_ack1_oe", 8'(bus.cascade_oe), 8'd0);
    bus.cascade_in = 3'd5;
    inta_high();
    inta_low();
    chk("s_hit_ack2_vec", 8'(bus.vector_drive_enable), 8'd1);
    inta_high();
    chk("s_hit_gap2_state", 8'(bus.ack_state), 8'd2);
    chk("s_hit_gap2_done", 8'(bus.sequence_done), 8'd0);
    inta_low();
    chk("s_hit_ack3_state", 8'(bus.ack_state), 8'd3);
    chk("s_hit_ack3_vec", 8'(bus.vector_drive_enable), 8'd1);
    inta_high();
    chk("s_hit_done", 8'(bus.sequence_done), 8'd1);
    chk("s_hit_end_state", 8'(bus.ack_state), 8'd0);
    inta_low();
    bus.cascade_in = 3'd3;
    inta_high();
    inta_low();
    chk("s_miss_ack2_vec", 8'(bus.vector_drive_enable), 8'd0);
    inta_high();
    inta_low();
    chk("s_miss_ack3_vec", 8'(bus.vector_drive_enable), 8'd0);
    inta_high();
    chk("s_miss_done", 8'(bus.sequence_done), 8'd1);
    bus.single_mode = 1'b1;
    bus.slave_program_n = 1'b1;
    wr_icw3(8'h04);
    bus.acknowledge_interrupt = 8'h04;
    chk("sg_cascade_slave", 8'(bus.cascade_slave), 8'd0);
    inta_low();
    chk("sg_ack1_oe", 8'(bus.cascade_oe), 8'd0);
    inta_high();
    inta_low();
    chk("sg_ack2_vec", 8'(bus.vector_drive_enable), 8'd1);
    chk("sg_ack2_oe", 8'(bus.cascade_oe), 8'd0);
    inta_high();
    chk("sg_gap2_done", 8'(bus.sequence_done), 8'd0);
    inta_low();
    chk("sg_ack3_vec", 8'(bus.vector_drive_enable), 8'd1);
    inta_high();
    chk("sg_done", 8'(bus.sequence_done), 8'd1);
    bus.single_mode = 1'b0;
    wr_icw4(8'h01);
    inta_low();
    inta_high();
    chk("i1_gap1_oe", 8'(bus.cascade_oe), 8'd1);
    bus.icw1_write = 1'b1;
    bus.icw3_write = 1'b1;
    bus.icw_data = 8'hFF;
    tick();
    bus.icw1_write = 1'b0;
    bus.icw3_write = 1'b0;
    chk("i1_state", 8'(bus.ack_state), 8'd0);
    chk("i1_oe", 8'(bus.cascade_oe), 8'd0);
    chk("i1_done", 8'(bus.sequence_done), 8'd0);
    tick();
    chk("i1_done_later", 8'(bus.sequence_done), 8'd0);
    inta_low();
    chk("i1_cfg_cleared_oe", 8'(bus.cascade_oe), 8'd0);
    chk("i1_cfg_cleared_state", 8'(bus.ack_state), 8'd1);
    bus.icw1_write = 1'b1;
    tick();
    bus.icw1_write = 1'b0;
    inta_high();
    wr_icw3(8'h04);
    wr_icw4(8'h01);
    inta_low();
    inta_high();
    inta_low();
    chk("ar_pre_oe", 8'(bus.cascade_oe), 8'd1);
    chk("ar_pre_state", 8'(bus.ack_state), 8'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_oe", 8'(bus.cascade_oe), 8'd0);
    chk("ar_out", 8'(bus.cascade_out), 8'd0);
    chk("ar_state", 8'(bus.ack_state), 8'd0);
    chk("ar_vec", 8'(bus.vector_drive_enable), 8'd0);
    bus.interrupt_ack_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
`ifdef BUFFERED_MODE_EN
    bus.slave_program_n = 1'b0;
    wr_icw3(8'h04);
    wr_icw4(8'h0D);
    chk("b_master", 8'(bus.cascade_slave), 8'd0);
    bus.acknowledge_interrupt = 8'h01;
    inta_low();
    chk("b_ack1_buf_en_n", 8'(bus.buffer_enable_n), 8'd1);
    inta_high();
    inta_low();
    chk("b_ack2_vec", 8'(bus.vector_drive_enable), 8'd1);
    chk("b_ack2_buf_en_n", 8'(bus.buffer_enable_n), 8'd0);
    inta_high();
    chk("b_done", 8'(bus.sequence_done), 8'd1);
    chk("b_idle_buf_en_n", 8'(bus.buffer_enable_n), 8'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
